// File: rtl/perceptron_pkg.sv
// perceptron_pkg: shared constants and types for the
// perceptron summation pipeline.
package perceptron_pkg;

  localparam int WEIGHT_NUM = 33;
  localparam int HIST_LEN   = 32;
  localparam int WEIGHT_W   = 8;
  localparam int SUM_W      = 16;
  localparam int THETA      = 75;

  localparam int GROUP_N  = 4;
  localparam int GROUP_SZ = 8;
  localparam int PSUM_W   = 13;

  typedef logic signed [WEIGHT_W-1:0] weight_t;
  typedef weight_t weight_vec_t [WEIGHT_NUM];
  typedef logic [HIST_LEN-1:0] hist_t;
  typedef logic signed [PSUM_W-1:0] psum_t;
  typedef logic signed [SUM_W-1:0] sum_t;

endpackage

// File: rtl/perceptron_partial_adder.sv
// perceptron_partial_adder: signed sum of 8 weights,
// each added or subtracted by its history bit.
module perceptron_partial_adder
  import perceptron_pkg::*;
(
  input  weight_t           w [GROUP_SZ],
  input  logic [GROUP_SZ-1:0] h,
  output psum_t             psum
);

  logic signed [WEIGHT_W:0] ext;
  psum_t acc;

  // 9-bit extension keeps -(-128) = +128 exact
  always_comb begin
    acc = '0;
    ext = '0;
    for (int i = 0; i < GROUP_SZ; i++) begin
      ext = (WEIGHT_W+1)'(w[i]);
      if (h[i])
        acc = acc + psum_t'(ext);
      else
        acc = acc - psum_t'(ext);
    end
  end

  assign psum = acc;

endmodule

// File: rtl/perceptron_sum_pipe.sv
// perceptron_sum_pipe: 3-stage perceptron dot product
// plus speculative global history with repair.
module perceptron_sum_pipe
  import perceptron_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  input  logic [WEIGHT_NUM*WEIGHT_W-1:0] weights,
  input  logic                         res_valid,
  input  logic                         res_outcome,
  input  logic                         res_pred,
  input  logic [HIST_LEN-1:0]          res_hist,
  output logic                         pred_valid,
  output logic                         prediction,
  output logic [SUM_W-1:0]             sum,
  output logic                         train_flag,
  output logic [HIST_LEN-1:0]          hist_tag,
  output logic [HIST_LEN-1:0]          ghist
);

  localparam sum_t THETA_S = sum_t'(THETA);

  logic        flush;
  weight_vec_t w_in;

  logic        s1_v;
  weight_vec_t s1_w;
  hist_t       s1_h;

  logic        s2_v;
  weight_t     s2_bias;
  psum_t       s2_ps [GROUP_N];
  psum_t       ps_c  [GROUP_N];
  hist_t       s2_h;

  sum_t        y_c;
  logic        pred_c;
  logic        train_c;

  assign flush = res_valid && (res_outcome != res_pred);

  // unpack the flat weight bus
  always_comb begin
    for (int i = 0; i < WEIGHT_NUM; i++)
      w_in[i] = weights[WEIGHT_W*i +: WEIGHT_W];
  end

  for (genvar g = 0; g < GROUP_N; g++) begin : g_grp
    weight_t gw [GROUP_SZ];

    // weights k+1 pair with history bit k
    always_comb begin
      for (int j = 0; j < GROUP_SZ; j++)
        gw[j] = s1_w[GROUP_SZ*g + j + 1];
    end

    perceptron_partial_adder u_add (
      .w    (gw),
      .h    (s1_h[GROUP_SZ*g +: GROUP_SZ]),
      .psum (ps_c[g])
    );
  end

  // final reduction: bias plus four partial sums
  always_comb begin
    y_c = sum_t'(s2_bias);
    for (int g = 0; g < GROUP_N; g++)
      y_c = y_c + sum_t'(s2_ps[g]);
    pred_c  = !y_c[SUM_W-1];
    train_c = (y_c <= THETA_S) && (y_c >= -THETA_S);
  end

  // stage valids; a mispredict kills everything in flight
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      s1_v       <= 1'b0;
      s2_v       <= 1'b0;
      pred_valid <= 1'b0;
    end else begin
      s1_v       <= req_valid;
      s2_v       <= s1_v;
      pred_valid <= s2_v;
    end
  end

  // S1 capture: weights and a stale history snapshot
  always_ff @(posedge clk) begin
    if (req_valid) begin
      s1_w <= w_in;
      s1_h <= ghist;
    end
  end

  // S2 capture: bias and partial sums
  always_ff @(posedge clk) begin
    if (s1_v) begin
      s2_bias <= s1_w[0];
      s2_ps   <= ps_c;
      s2_h    <= s1_h;
    end
  end

  // S3 registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      sum        <= '0;
      prediction <= 1'b0;
      train_flag <= 1'b0;
      hist_tag   <= '0;
    end else if (s2_v) begin
      sum        <= y_c;
      prediction <= pred_c;
      train_flag <= train_c;
      hist_tag   <= s2_h;
    end
  end

  // history: repair beats speculative shift
  always_ff @(posedge clk) begin
    if (rst)
      ghist <= '0;
    else if (flush)
      ghist <= {res_hist[HIST_LEN-2:0], res_outcome};
    else if (pred_valid)
      ghist <= {ghist[HIST_LEN-2:0], prediction};
  end

endmodule

// File: tb/tb_perceptron_sum_pipe.sv
// tb_perceptron_sum_pipe: directed and random checks
// against a queue-based reference model.
module tb_perceptron_sum_pipe;
  import perceptron_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [WEIGHT_NUM*8-1:0] weights;
  logic        res_valid;
  logic        res_outcome;
  logic        res_pred;
  logic [31:0] res_hist;
  logic        pred_valid;
  logic        prediction;
  logic [15:0] sum;
  logic        train_flag;
  logic [31:0] hist_tag;
  logic [31:0] ghist;

  always #5 clk = ~clk;

  perceptron_sum_pipe dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .weights     (weights),
    .res_valid   (res_valid),
    .res_outcome (res_outcome),
    .res_pred    (res_pred),
    .res_hist    (res_hist),
    .pred_valid  (pred_valid),
    .prediction  (prediction),
    .sum         (sum),
    .train_flag  (train_flag),
    .hist_tag    (hist_tag),
    .ghist       (ghist)
  );

  int tests = 0;
  int fails = 0;
  int tw [WEIGHT_NUM];
  int pv_cnt;

  typedef struct {
    int          y;
    logic [31:0] h;
    int          age;
  } ent_t;

  ent_t        q [$];
  logic [31:0] m_ghist;
  logic        m_pv;
  int          m_y;
  logic [31:0] m_tag;

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sx(logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic int ref_y(logic [31:0] h);
    int y;
    y = tw[0];
    for (int k = 0; k < 32; k++)
      if (h[k]) y += tw[k+1];
      else      y -= tw[k+1];
    return y;
  endfunction

  task automatic pack_w();
    for (int i = 0; i < WEIGHT_NUM; i++)
      weights[8*i +: 8] = tw[i][7:0];
  endtask

  task automatic rand_w();
    int mode;
    mode = $urandom_range(0, 3);
    for (int i = 0; i < WEIGHT_NUM; i++) begin
      if (mode == 0)
        tw[i] = $urandom_range(0, 1) ? 127 : -128;
      else
        tw[i] = int'($urandom_range(0, 255)) - 128;
    end
    pack_w();
  endtask

  task automatic step();
    logic        fl;
    logic [31:0] gn;
    fl = res_valid && (res_outcome != res_pred);
    if (rst) begin
      q.delete();
      m_pv    = 1'b0;
      m_ghist = '0;
    end else begin
      if (fl)
        gn = {res_hist[30:0], res_outcome};
      else if (m_pv)
        gn = {m_ghist[30:0], m_y >= 0};
      else
        gn = m_ghist;
      if (fl) begin
        q.delete();
        m_pv = 1'b0;
      end else begin
        if (q.size() > 0 && q[0].age == 3)
          void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (req_valid)
          q.push_back('{y: ref_y(m_ghist),
                        h: m_ghist, age: 1});
        if (q.size() > 0 && q[0].age == 3) begin
          m_pv  = 1'b1;
          m_y   = q[0].y;
          m_tag = q[0].h;
        end else begin
          m_pv = 1'b0;
        end
      end
      m_ghist = gn;
    end
    @(posedge clk);
    #1;
    if (pred_valid) pv_cnt++;
    check("pred_valid", {31'd0, pred_valid}, {31'd0, m_pv});
    check("ghist", ghist, m_ghist);
    if (m_pv) begin
      check("sum", sx(sum), m_y);
      check("prediction", {31'd0, prediction},
            {31'd0, m_y >= 0});
      check("train_flag", {31'd0, train_flag},
            {31'd0, (m_y <= 75) && (m_y >= -75)});
      check("hist_tag", hist_tag, m_tag);
    end
    if (rst) begin
      check("rst_sum", sx(sum), 32'd0);
      check("rst_pred", {31'd0, prediction}, 32'd0);
      check("rst_train", {31'd0, train_flag}, 32'd0);
      check("rst_tag", hist_tag, 32'd0);
    end
  endtask

  task automatic repair(logic [31:0] h, logic outc,
                        logic req);
    res_valid   = 1'b1;
    res_outcome = outc;
    res_pred    = ~outc;
    res_hist    = h;
    req_valid   = req;
    step();
    res_valid = 1'b0;
    req_valid = 1'b0;
  endtask

  task automatic fire();
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
  endtask

  task automatic set_all(int b, int v);
    tw[0] = b;
    for (int i = 1; i < WEIGHT_NUM; i++) tw[i] = v;
    pack_w();
  endtask

  initial begin
    rst         = 1'b1;
    req_valid   = 1'b0;
    weights     = '0;
    res_valid   = 1'b0;
    res_outcome = 1'b0;
    res_pred    = 1'b0;
    res_hist    = '0;
    pv_cnt      = 0;
    m_pv        = 1'b0;
    m_y         = 0;
    m_tag       = '0;
    m_ghist     = '0;
    step();
    step();
    rst = 1'b0;

    set_all(0, 0);
    fire();
    check("zero_pv", {31'd0, pred_valid}, 32'd1);
    check("zero_sum", sx(sum), 32'd0);
    check("zero_pred", {31'd0, prediction}, 32'd1);
    check("zero_train", {31'd0, train_flag}, 32'd1);
    step();
    check("zero_ghist", ghist, 32'h1);

    repair(32'hFFFF_FFFF, 1'b1, 1'b0);
    check("rep_ones", ghist, 32'hFFFF_FFFF);
    set_all(10, 1);
    fire();
    check("w42_sum", sx(sum), 32'd42);
    check("w42_pred", {31'd0, prediction}, 32'd1);
    check("w42_train", {31'd0, train_flag}, 32'd1);
    repair(32'h0, 1'b0, 1'b0);
    fire();
    check("wm22_sum", sx(sum), 32'(-22));
    check("wm22_pred", {31'd0, prediction}, 32'd0);

    set_all(-128, -128);
    repair(32'h0, 1'b0, 1'b0);
    fire();
    check("min_h0_sum", sx(sum), 32'd3968);
    check("min_h0_train", {31'd0, train_flag}, 32'd0);
    repair(32'hFFFF_FFFF, 1'b1, 1'b0);
    fire();
    check("min_h1_sum", sx(sum), 32'(-4224));
    check("min_h1_pred", {31'd0, prediction}, 32'd0);
    step();

    pv_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      rand_w();
      req_valid = 1'b1;
      step();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("b2b_count", pv_cnt, 32'd5);

    rand_w();
    req_valid = 1'b1;
    step();
    step();
    pv_cnt = 0;
    repair(32'h0000_000F, 1'b0, 1'b0);
    check("flush_ghist", ghist, 32'h0000_001E);
    for (int i = 0; i < 3; i++) step();
    check("flush_drop", pv_cnt, 32'd0);

    rand_w();
    fire();
    check("coll_pv", {31'd0, pred_valid}, 32'd1);
    pv_cnt = 0;
    repair(32'h1234_5678, 1'b1, 1'b1);
    check("coll_ghist", ghist, 32'h2468_ACF1);
    for (int i = 0; i < 4; i++) step();
    check("coll_drop", pv_cnt, 32'd0);

    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_w();
      step();
    end
    rst = 1'b1;
    step();
    check("mid_rst_pv", {31'd0, pred_valid}, 32'd0);
    check("mid_rst_ghist", ghist, 32'd0);
    rst       = 1'b0;
    req_valid = 1'b0;
    pv_cnt    = 0;
    for (int i = 0; i < 4; i++) step();
    check("mid_rst_drop", pv_cnt, 32'd0);

    for (int n = 0; n < 400; n++) begin
      rand_w();
      rst         = ($urandom_range(0, 99) == 0);
      req_valid   = ($urandom_range(0, 3) != 0);
      res_valid   = ($urandom_range(0, 7) == 0);
      res_outcome = $urandom_range(0, 1);
      res_pred    = $urandom_range(0, 1);
      res_hist    = $urandom;
      step();
    end
    rst       = 1'b0;
    req_valid = 1'b0;
    res_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
